// File: rtl/apb_pkg.sv
// Shared APB definitions for the 16-word APB slave and the master bridge.
package apb_pkg;

    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response handshake plus APB bus seen by the master bridge.
interface apb_master_bridge_if import apb_pkg::*; #(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic              resp_err_o;
    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; expired_o flags the wait cycle that would reach TIMEOUT.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Raised while the increment in progress is the TIMEOUT-th stalled cycle.
    assign expired_o = en_i && (cnt_q >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request to APB master bridge with ACCESS-phase timeout and one-cycle response pulse.
module apb_master_bridge import apb_pkg::*; #(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus
);

    apb_mst_state_e    state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              tmr_clear, tmr_en, tmr_expired;

    assign tmr_clear = (state_q != ACCESS);
    assign tmr_en    = (state_q == ACCESS) && !bus.pready_i;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Outputs are decoded from the next state so every bus pin comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        psel_d       = 1'b0;
        penable_d    = 1'b0;
        paddr_d      = '0;
        pwrite_d     = 1'b0;
        pwdata_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i && req_ready_q) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = bus.req_addr_i;
                    pwrite_d = bus.req_write_i;
                    pwdata_d = bus.req_write_i ? bus.req_wdata_i : '0;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                paddr_d   = paddr_q;
                pwrite_d  = pwrite_q;
                pwdata_d  = pwdata_q;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = pwrite_q ? '0 : bus.prdata_i;
                end else if (tmr_expired) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    paddr_d   = paddr_q;
                    pwrite_d  = pwrite_q;
                    pwdata_d  = pwdata_q;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.psel_o       = psel_q;
    assign bus.penable_o    = penable_q;
    assign bus.paddr_o      = paddr_q;
    assign bus.pwrite_o     = pwrite_q;
    assign bus.pwdata_o     = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB slave model with programmable wait states plus a transaction-level reference model.
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;
    localparam int FOREVER = 1000;

    logic clk;
    logic rst;

    apb_master_bridge_if #(.ADDR_W(4), .DATA_W(32)) bif ();

    apb_master_bridge #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // APB slave: asserts pready after slave_waits stalled ACCESS cycles; noise outside ACCESS.
    int          slave_waits = 0;
    int          acc_n = 0;
    logic [31:0] smem [16] = '{default: 32'h0};

    always @(negedge clk) begin
        if (bif.psel_o && bif.penable_o) begin
            acc_n = acc_n + 1;
            if (acc_n > slave_waits) begin
                bif.pready_i = 1'b1;
                if (bif.pwrite_o) begin
                    bif.prdata_i = $urandom;
                    smem[bif.paddr_o] = bif.pwdata_o;
                end else begin
                    bif.prdata_i = smem[bif.paddr_o];
                end
            end else begin
                bif.pready_i = 1'b0;
                bif.prdata_i = $urandom;
            end
        end else begin
            acc_n = 0;
            bif.pready_i = 1'($urandom_range(0, 1));
            bif.prdata_i = $urandom;
        end
    end

    // Reference model: a transaction either completes within TIMEOUT access cycles or aborts.
    logic [31:0] ref_mem [16] = '{default: 32'h0};

    task automatic model(input bit wr, input logic [3:0] a, input logic [31:0] d, input int w,
                         output bit e, output logic [31:0] r, output int lat);
        if (w < TIMEOUT) begin
            e   = 1'b0;
            r   = wr ? 32'h0 : ref_mem[a];
            lat = 3 + w;
            if (wr) ref_mem[a] = d;
        end else begin
            e   = 1'b1;
            r   = 32'h0;
            lat = 2 + TIMEOUT;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input bit wr, input logic [3:0] a, input logic [31:0] d, input int w,
                          output bit got_err, output logic [31:0] got_rd, output int got_lat);
        bit acc;
        bit seen;
        int n;
        got_err = 1'b0;
        got_rd  = 32'h0;
        got_lat = -1;
        @(negedge clk);
        bif.req_write_i = wr;
        bif.req_addr_i  = a;
        bif.req_wdata_i = d;
        bif.req_valid_i = 1'b1;
        slave_waits     = w;
        acc = bif.req_ready_o;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bif.req_ready_o;
        end
        if (!acc) begin
            chk("accept_timeout", 32'h0, 32'h1);
            bif.req_valid_i = 1'b0;
            return;
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            bif.req_valid_i = 1'b0;
            bif.req_write_i = 1'($urandom_range(0, 1));
            bif.req_addr_i  = 4'($urandom_range(0, 15));
            bif.req_wdata_i = $urandom;
            if (bif.resp_valid_o) begin
                seen    = 1'b1;
                got_err = bif.resp_err_o;
                got_rd  = bif.resp_rdata_o;
                got_lat = n;
                chk("resp_psel", 32'(bif.psel_o), 32'h0);
                chk("resp_penable", 32'(bif.penable_o), 32'h0);
                chk("resp_paddr", 32'(bif.paddr_o), 32'h0);
                chk("resp_pwdata", bif.pwdata_o, 32'h0);
            end else begin
                chk("psel", 32'(bif.psel_o), 32'h1);
                chk("penable", 32'(bif.penable_o), 32'(n >= 2));
                chk("paddr", 32'(bif.paddr_o), 32'(a));
                chk("pwrite", 32'(bif.pwrite_o), 32'(wr));
                chk("pwdata", bif.pwdata_o, wr ? d : 32'h0);
                chk("busy_ready", 32'(bif.req_ready_o), 32'h0);
            end
        end
        if (!seen) begin
            chk("resp_timeout", 32'h0, 32'h1);
        end else begin
            @(negedge clk);
            chk("post_resp_valid", 32'(bif.resp_valid_o), 32'h0);
            chk("post_resp_rdata", bif.resp_rdata_o, 32'h0);
            chk("post_resp_err", 32'(bif.resp_err_o), 32'h0);
            chk("post_resp_ready", 32'(bif.req_ready_o), 32'h1);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          waits;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [3:0] a, logic [31:0] d, int w,
                                bit e, logic [31:0] r, int lat);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.waits = w;
        v.exp_err = e; v.exp_rdata = r; v.exp_lat = lat;
        return v;
    endfunction

    typedef struct {
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    vec_t tbl [8];
    exp_t expq [$];

    initial begin
        bit          g_err, m_err;
        logic [31:0] g_rd, m_rd;
        int          g_lat, m_lat;
        int          hits;

        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          g_err, m_err;
        logic [31:0] g_rd, m_rd;
        int          g_lat, m_lat;
        int          hits, idx, nresp;
        int          wopt [8];

        tbl[0] = mk(1'b1, 4'h3, 32'hDEAD_BEEF, 0,       1'b0, 32'h0,         3);
        tbl[1] = mk(1'b0, 4'h3, 32'h0,         2,       1'b0, 32'hDEAD_BEEF, 5);
        tbl[2] = mk(1'b0, 4'h5, 32'h0,         FOREVER, 1'b1, 32'h0,         18);
        tbl[3] = mk(1'b1, 4'h7, 32'h1234_5678, 0,       1'b0, 32'h0,         3);
        tbl[4] = mk(1'b0, 4'h7, 32'h0,         15,      1'b0, 32'h1234_5678, 18);
        tbl[5] = mk(1'b1, 4'h9, 32'hA5A5_A5A5, 16,      1'b1, 32'h0,         18);
        tbl[6] = mk(1'b0, 4'h9, 32'h0,         0,       1'b0, 32'h0,         3);
        tbl[7] = mk(1'b0, 4'h3, 32'h0,         1,       1'b0, 32'hDEAD_BEEF, 4);
        wopt = '{0, 0, 1, 2, 3, 15, 16, 25};

        rst = 1'b1;
        bif.req_valid_i = 1'b0;
        bif.req_write_i = 1'b0;
        bif.req_addr_i  = 4'h0;
        bif.req_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bif.req_ready_o), 32'h0);
        chk("rst_psel", 32'(bif.psel_o), 32'h0);
        chk("rst_penable", 32'(bif.penable_o), 32'h0);
        chk("rst_resp_valid", 32'(bif.resp_valid_o), 32'h0);
        chk("rst_paddr", 32'(bif.paddr_o), 32'h0);
        chk("rst_pwdata", bif.pwdata_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bif.req_ready_o), 32'h1);

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, m_err, m_rd, m_lat);
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, g_err, g_rd, g_lat);
            chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(tbl[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), g_rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(tbl[i].exp_lat));
        end

        // Reset during ACCESS of a write: bus drops at once and the request never answers.
        @(negedge clk);
        bif.req_write_i = 1'b1;
        bif.req_addr_i  = 4'h2;
        bif.req_wdata_i = 32'hCAFE_F00D;
        bif.req_valid_i = 1'b1;
        slave_waits     = FOREVER;
        chk("rstmid_ready", 32'(bif.req_ready_o), 32'h1);
        @(negedge clk);
        bif.req_valid_i = 1'b0;
        chk("rstmid_setup_psel", 32'(bif.psel_o), 32'h1);
        @(negedge clk);
        chk("rstmid_access_penable", 32'(bif.penable_o), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_psel", 32'(bif.psel_o), 32'h0);
        chk("rstmid_penable", 32'(bif.penable_o), 32'h0);
        chk("rstmid_ready_low", 32'(bif.req_ready_o), 32'h0);
        chk("rstmid_resp_valid", 32'(bif.resp_valid_o), 32'h0);
        rst = 1'b0;
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bif.resp_valid_o) hits++;
        end
        chk("rstmid_no_resp", 32'(hits), 32'h0);
        chk("rstmid_ready_back", 32'(bif.req_ready_o), 32'h1);
        model(1'b0, 4'h2, 32'h0, 0, m_err, m_rd, m_lat);
        do_txn(1'b0, 4'h2, 32'h0, 0, g_err, g_rd, g_lat);
        chk("after_rst_rd_rdata", g_rd, m_rd);
        chk("after_rst_rd_lat", 32'(g_lat), 32'(m_lat));
        model(1'b1, 4'h2, 32'h0BAD_CAFE, 1, m_err, m_rd, m_lat);
        do_txn(1'b1, 4'h2, 32'h0BAD_CAFE, 1, g_err, g_rd, g_lat);
        chk("after_rst_wr_err", 32'(g_err), 32'(m_err));
        chk("after_rst_wr_lat", 32'(g_lat), 32'(m_lat));

        // Random transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            bit          wr;
            logic [3:0]  a;
            logic [31:0] d;
            int          w;
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
            w  = wopt[$urandom_range(0, 7)];
            model(wr, a, d, w, m_err, m_rd, m_lat);
            do_txn(wr, a, d, w, g_err, g_rd, g_lat);
            chk($sformatf("rnd%0d_err", i), 32'(g_err), 32'(m_err));
            chk($sformatf("rnd%0d_rdata", i), g_rd, m_rd);
            chk($sformatf("rnd%0d_lat", i), 32'(g_lat), 32'(m_lat));
        end

        // Back-to-back: 16 writes then 16 reads with req_valid held high throughout.
        idx = 0;
        nresp = 0;
        for (int c = 0; c < 600 && nresp < 32; c++) begin
            @(negedge clk);
            if (bif.resp_valid_o) begin
                if (expq.size() == 0) begin
                    chk("b2b_extra_resp", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk($sformatf("b2b%0d_err", nresp), 32'(bif.resp_err_o), 32'(e.err));
                    chk($sformatf("b2b%0d_rdata", nresp), bif.resp_rdata_o, e.rdata);
                end
                nresp++;
            end
            if (idx < 32) begin
                logic [3:0] a;
                a = 4'(idx % 16);
                bif.req_write_i = (idx < 16);
                bif.req_addr_i  = a;
                bif.req_wdata_i = 32'(a) * 32'h0101_0101;
                bif.req_valid_i = 1'b1;
                if (bif.req_ready_o) begin
                    exp_t e;
                    slave_waits = $urandom_range(0, 2);
                    model(idx < 16, a, 32'(a) * 32'h0101_0101, slave_waits, m_err, m_rd, m_lat);
                    e.err = m_err;
                    e.rdata = m_rd;
                    expq.push_back(e);
                    idx++;
                end
            end else begin
                bif.req_valid_i = 1'b0;
            end
        end
        bif.req_valid_i = 1'b0;
        chk("b2b_accepted", 32'(idx), 32'd32);
        chk("b2b_responses", 32'(nresp), 32'd32);
        repeat (5) @(negedge clk);
        chk("b2b_no_trailing_resp", 32'(bif.resp_valid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
